// File: rtl/mms_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mms_pkg
// Description : Shared types and constants for the min/max stream controller:
//               the controller state encoding, the mode encodings and the
//               default operand width.
// Revision    : 1.0 - initial release
// ============================================================================
package mms_pkg;

    // Default operand width
    localparam int MMS_DATA_W = 8;

    // Mode encodings, sampled with the first operand of a frame
    localparam logic MMS_SEL_MIN = 1'b1;
    localparam logic MMS_SEL_MAX = 1'b0;

    // Controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } mms_state_t;

endpackage : mms_pkg
`default_nettype wire

// File: rtl/mms_cmp_sel.sv
`default_nettype none
// ============================================================================
// Module      : mms_cmp_sel
// Description : Combinational compare/select decision. Raises replace when the
//               new operand a should displace the running winner b. Strict
//               comparisons mean ties keep the earlier operand.
// Revision    : 1.0 - initial release
// ============================================================================
module mms_cmp_sel
    import mms_pkg::*;
#(
    parameter int DATA_W = MMS_DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              mode,
    output logic              replace
);

    // Unsigned strict compare in the direction selected by mode
    always_comb begin
        replace = 1'b0;
        if (mode == MMS_SEL_MIN) begin
            replace = (a < b);
        end else begin
            replace = (a > b);
        end
    end

endmodule : mms_cmp_sel
`default_nettype wire

// File: rtl/mms_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mms_stream_ctrl
// Description : Streams FRAME_LEN unsigned operands per frame and reports the
//               minimum or maximum (chosen by select on the first operand)
//               together with its position in the frame. The result is held
//               on a valid/ready output until taken.
// Revision    : 1.0 - initial release
// ============================================================================
module mms_stream_ctrl
    import mms_pkg::*;
#(
    parameter  int FRAME_LEN = 8,
    parameter  int DATA_W    = MMS_DATA_W,
    localparam int IDX_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              select,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_index,
    output logic              busy
);

    // The counter is sized to reach FRAME_LEN so the final increment of a
    // frame never wraps, even when FRAME_LEN is a power of two.
    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(FRAME_LEN - 1);

    mms_state_t        r_state;
    mms_state_t        w_next_state;
    logic [DATA_W-1:0] r_run_val;
    logic [IDX_W-1:0]  r_run_idx;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_mode;
    logic              w_accept;
    logic              w_last;
    logic              w_replace;

    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_cnt == C_LAST);
    assign out_data  = r_run_val;
    assign out_index = r_run_idx;

    mms_cmp_sel #(
        .DATA_W (DATA_W)
    ) u_cmp_sel (
        .a       (in_data),
        .b       (r_run_val),
        .mode    (r_mode),
        .replace (w_replace)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and handshake outputs
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b1;
        out_valid    = 1'b0;
        busy         = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (in_valid) begin
                    w_next_state = ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid && w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Running winner, its index, operand count and latched mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run_val <= '0;
            r_run_idx <= '0;
            r_cnt     <= '0;
            r_mode    <= MMS_SEL_MAX;
        end else if (w_accept) begin
            if (r_state == IDLE) begin
                r_run_val <= in_data;
                r_run_idx <= '0;
                r_cnt     <= CNT_W'(1);
                r_mode    <= select;
            end else begin
                if (w_replace) begin
                    r_run_val <= in_data;
                    r_run_idx <= r_cnt[IDX_W-1:0];
                end
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule : mms_stream_ctrl
`default_nettype wire
